// File: rtl/calc_pkg.sv
// Shared types for the calculator core: FSM state codes (also driven on Status)
// and ALU opcodes.
package calc_pkg;

  typedef enum logic [2:0] {
    S_OPA    = 3'b001,
    S_OPB    = 3'b010,
    S_OP     = 3'b100,
    S_RESULT = 3'b111
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_t;

  // Packed snapshot width for a given operand width: {state, A, B, Op}.
  function automatic int snap_width(input int width);
    return $bits(state_t) + 2 * width + $bits(op_t);
  endfunction

endpackage

// File: rtl/undo_history.sv
// Circular LIFO of snapshots. Push onto a full buffer overwrites the oldest
// entry, so the newest DEPTH snapshots are always kept. Pop takes priority
// over push and is ignored when the buffer is empty.
module undo_history #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 8
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ENTRY_W-1:0]           din,
  output logic [ENTRY_W-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   top_ptr;
  logic               do_pop;
  logic               do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_dec(input logic [PTR_W-1:0] p);
    return (p == '0) ? PTR_W'(DEPTH - 1) : p - 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && !do_pop;
  assign top_ptr = ptr_dec(wr_ptr);
  assign dout    = mem[top_ptr];

  // Write pointer and occupancy; occupancy saturates at DEPTH on overwrite.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (do_pop) begin
      wr_ptr <= top_ptr;
      count  <= count - 1'b1;
    end else if (do_push) begin
      wr_ptr <= ptr_inc(wr_ptr);
      if (count != CNT_W'(DEPTH)) count <= count + 1'b1;
    end
  end

  // Snapshot storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/calc_multi_undo.sv
// Calculator core with operand entry FSM, combinational ALU, result chaining
// and a multi-level undo history.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_OPA    | waiting for operand A
//   S_OPB    | waiting for operand B
//   S_OP     | waiting for opcode (DataIn[1:0])
//   S_RESULT | showing result; Enter chains it into A
module calc_multi_undo
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int UNDO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              resetN,
  input  logic                              Enter,
  input  logic                              Undo,
  input  logic [WIDTH-1:0]                  DataIn,
  output logic [WIDTH-1:0]                  ToDisplay,
  output logic [3:0]                        Flags,
  output logic [2:0]                        Status,
  output logic [$clog2(UNDO_DEPTH+1)-1:0]   HistCount
);

  typedef struct packed {
    state_t           state;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_t              op;
  } snapshot_t;

  localparam int SNAP_W = snap_width(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  op_t              op_q, op_d;
  logic             push, pop;
  logic [SNAP_W-1:0] hist_dout;
  snapshot_t        snap_in, snap_out;
  logic [WIDTH-1:0] result;
  logic [WIDTH:0]   sum_ext;
  logic             carry, ovf;

  assign snap_in  = '{state: state_q, a: a_q, b: b_q, op: op_q};
  assign snap_out = snapshot_t'(hist_dout);

  undo_history #(
    .DEPTH   (UNDO_DEPTH),
    .ENTRY_W (SNAP_W)
  ) u_hist (
    .clk    (clk),
    .resetN (resetN),
    .push   (push),
    .pop    (pop),
    .din    (snap_in),
    .dout   (hist_dout),
    .count  (HistCount)
  );

  // Datapath and state register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= S_OPA;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
    end
  end

  // Next state: Undo beats Enter; every accepted Enter snapshots the pre-edge values.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    push    = 1'b0;
    pop     = 1'b0;
    if (Undo) begin
      if (HistCount != '0) begin
        pop     = 1'b1;
        state_d = snap_out.state;
        a_d     = snap_out.a;
        b_d     = snap_out.b;
        op_d    = snap_out.op;
      end
    end else if (Enter) begin
      push = 1'b1;
      case (state_q)
        S_OPA: begin
          a_d     = DataIn;
          state_d = S_OPB;
        end
        S_OPB: begin
          b_d     = DataIn;
          state_d = S_OP;
        end
        S_OP: begin
          op_d    = op_t'(DataIn[1:0]);
          state_d = S_RESULT;
        end
        S_RESULT: begin
          a_d     = result;
          state_d = S_OPB;
        end
        default: state_d = S_OPA;
      endcase
    end
  end

  // ALU: purely a function of A, B, Op so a restored snapshot restores the result.
  always_comb begin
    sum_ext = '0;
    result  = '0;
    carry   = 1'b0;
    ovf     = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum_ext = {1'b0, a_q} + {1'b0, b_q};
        result  = sum_ext[WIDTH-1:0];
        carry   = sum_ext[WIDTH];
        ovf     = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        result = a_q - b_q;
        carry  = (a_q < b_q);
        ovf    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (result[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: result = a_q & b_q;
      OP_OR:  result = a_q | b_q;
      default: result = '0;
    endcase
  end

  assign Status    = state_q;
  assign ToDisplay = (state_q == S_RESULT) ? result : DataIn;
  assign Flags     = (state_q == S_RESULT) ? {result[WIDTH-1], (result == '0), carry, ovf} : 4'b0000;

endmodule

// File: tb/tb_calc_multi_undo.sv
// Randomised plus directed bench for calc_multi_undo with a queue-based
// scoreboard and an abstract reference model (stage index, integer operands,
// history queue).
module tb_calc_multi_undo;

  localparam int W = 16;
  localparam int D = 4;
  localparam int MASK = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          resetN = 1'b0;
  logic          Enter = 1'b0;
  logic          Undo = 1'b0;
  logic [W-1:0]  DataIn = '0;
  logic [W-1:0]  ToDisplay;
  logic [3:0]    Flags;
  logic [2:0]    Status;
  logic [2:0]    HistCount;

  calc_multi_undo #(.WIDTH(W), .UNDO_DEPTH(D)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .Enter     (Enter),
    .Undo      (Undo),
    .DataIn    (DataIn),
    .ToDisplay (ToDisplay),
    .Flags     (Flags),
    .Status    (Status),
    .HistCount (HistCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] disp;
    logic [3:0]   flags;
    logic [2:0]   status;
    logic [2:0]   hist;
    string        name;
  } exp_t;

  typedef struct {
    int stage;
    int a;
    int b;
    int op;
  } snap_t;

  exp_t  exp_q[$];
  snap_t hist[$];
  int    m_stage, m_a, m_b, m_op;
  int    n_checks = 0;
  int    n_errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endfunction

  function automatic int sx(input int x);
    return (x >= (1 << (W - 1))) ? x - (1 << W) : x;
  endfunction

  function automatic void model_reset();
    m_stage = 0; m_a = 0; m_b = 0; m_op = 0;
    hist.delete();
  endfunction

  function automatic int model_result();
    case (m_op)
      0: return (m_a + m_b) & MASK;
      1: return (m_a - m_b) & MASK;
      2: return m_a & m_b;
      default: return m_a | m_b;
    endcase
  endfunction

  function automatic logic [3:0] model_flags();
    int r, c, v, s;
    r = model_result();
    c = 0; v = 0;
    if (m_op == 0) begin
      c = (m_a + m_b) > MASK;
      s = sx(m_a) + sx(m_b);
      v = (s > 32767) || (s < -32768);
    end else if (m_op == 1) begin
      c = m_a < m_b;
      s = sx(m_a) - sx(m_b);
      v = (s > 32767) || (s < -32768);
    end
    return {r[W-1] == 1'b1, r == 0, c != 0, v != 0};
  endfunction

  function automatic logic [2:0] stage_code(input int st);
    case (st)
      0: return 3'b001;
      1: return 3'b010;
      2: return 3'b100;
      default: return 3'b111;
    endcase
  endfunction

  function automatic void push_expected(input string nm);
    exp_t e;
    e.name   = nm;
    e.status = stage_code(m_stage);
    e.hist   = 3'(hist.size());
    if (m_stage == 3) begin
      e.disp  = W'(model_result());
      e.flags = model_flags();
    end else begin
      e.disp  = DataIn;
      e.flags = 4'b0000;
    end
    exp_q.push_back(e);
  endfunction

  // One clock of stimulus: drive inputs, advance the model, queue expectation.
  task automatic cycle(input bit en, input bit un, input logic [W-1:0] din, input string nm);
    snap_t s;
    @(negedge clk);
    Enter = en; Undo = un; DataIn = din;
    if (un) begin
      if (hist.size() > 0) begin
        s = hist.pop_back();
        m_stage = s.stage; m_a = s.a; m_b = s.b; m_op = s.op;
      end
    end else if (en) begin
      hist.push_back('{stage: m_stage, a: m_a, b: m_b, op: m_op});
      if (hist.size() > D) void'(hist.pop_front());
      case (m_stage)
        0: begin m_a = int'(din); m_stage = 1; end
        1: begin m_b = int'(din); m_stage = 2; end
        2: begin m_op = int'(din) & 3; m_stage = 3; end
        default: begin m_a = model_result(); m_stage = 1; end
      endcase
    end
    push_expected(nm);
  endtask

  task automatic undo_all();
    for (int i = 0; i < D + 1; i++) cycle(0, 1, 16'h0, "undo_all");
  endtask

  // Monitor: outputs settle right after each active edge; compare there.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.name, ".disp"},   32'(ToDisplay), 32'(e.disp));
        chk({e.name, ".flags"},  32'(Flags),     32'(e.flags));
        chk({e.name, ".status"}, 32'(Status),    32'(e.status));
        chk({e.name, ".hist"},   32'(HistCount), 32'(e.hist));
      end
    end
  end

  initial begin
    int r;
    model_reset();
    DataIn = 16'h1234;
    repeat (2) @(negedge clk);
    chk("reset.status", 32'(Status), 32'h1);
    chk("reset.hist",   32'(HistCount), 32'h0);
    chk("reset.flags",  32'(Flags), 32'h0);
    chk("reset.disp",   32'(ToDisplay), 32'h1234);
    @(negedge clk);
    resetN = 1'b1;

    // ADD overflow, then full rollback and an extra Undo on empty history.
    cycle(1, 0, 16'h7FFF, "add.a");
    cycle(1, 0, 16'h0001, "add.b");
    cycle(1, 0, 16'h0000, "add.op");
    chk("add.exp_disp",  32'(exp_q[$].disp), 32'h8000);
    chk("add.exp_flags", 32'(exp_q[$].flags), 32'b1001);
    undo_all();

    // SUB with borrow.
    cycle(1, 0, 16'h0003, "sub.a");
    cycle(1, 0, 16'h0005, "sub.b");
    cycle(1, 0, 16'h0001, "sub.op");
    chk("sub.exp_disp",  32'(exp_q[$].disp), 32'hFFFE);
    chk("sub.exp_flags", 32'(exp_q[$].flags), 32'b1010);
    undo_all();

    // History overflow: six Enters, five Undos.
    cycle(1, 0, 16'h0010, "ovf.a");
    cycle(1, 0, 16'h0020, "ovf.b");
    cycle(1, 0, 16'h0000, "ovf.op");
    cycle(1, 0, 16'h0000, "ovf.chain");
    cycle(1, 0, 16'h0005, "ovf.b2");
    cycle(1, 0, 16'h0001, "ovf.op2");
    undo_all();
    // Returned to S_OP with A=0x10, B=0x20: choosing ADD shows 0x30.
    cycle(1, 0, 16'h0000, "ovf.readd");
    undo_all();
    undo_all();

    // Same-cycle Enter+Undo in S_OPB with one snapshot.
    cycle(1, 0, 16'h00AA, "same.a");
    cycle(1, 1, 16'h00BB, "same.both");
    cycle(0, 0, 16'h00CC, "same.idle");

    // Asynchronous reset while in S_OP.
    cycle(1, 0, 16'h0100, "ar.a");
    cycle(1, 0, 16'h0200, "ar.b");
    cycle(0, 0, 16'h4321, "ar.idle");
    @(negedge clk);
    #2;
    resetN = 1'b0;
    model_reset();
    #1;
    chk("areset.status", 32'(Status), 32'h1);
    chk("areset.hist",   32'(HistCount), 32'h0);
    chk("areset.flags",  32'(Flags), 32'h0);
    chk("areset.disp",   32'(ToDisplay), 32'h4321);
    @(negedge clk);
    resetN = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 4)      cycle(1, 0, W'($urandom), "rnd.enter");
      else if (r <= 6) cycle(0, 1, W'($urandom), "rnd.undo");
      else if (r == 7) cycle(1, 1, W'($urandom), "rnd.both");
      else             cycle(0, 0, W'($urandom), "rnd.idle");
    end
    cycle(0, 0, 16'h0, "tail");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
    chk("drain.queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
